// File: rtl/dual_rail_decoder_if.sv
// Bus between the dual-rail core, the decoder and the single-rail consumer.
// The slave modport is the decoder's view of the bus; master is the surrounding logic.
interface dual_rail_decoder_if #(
  parameter int N = 128
);
  logic [N-1:0] in_t;
  logic [N-1:0] in_f;
  logic         ack;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         err;
  logic [1:0]   err_code;
  logic         err_clr;

  modport slave (
    input  in_t, in_f, out_ready, err_clr,
    output ack, out_data, out_valid, err, err_code
  );

  modport master (
    output in_t, in_f, out_ready, err_clr,
    input  ack, out_data, out_valid, err, err_code
  );
endinterface

// File: rtl/dual_rail_decoder.sv
// Return-to-spacer dual-rail receiver: completion/legality detection, single-rail handoff, 4-phase ack.
// Optional completion timeout is compiled in when DUAL_RAIL_DEC_TIMEOUT_EN is defined.
module dual_rail_decoder #(
  parameter int N       = 128,
  parameter int TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  dual_rail_decoder_if.slave dr_if
);
  // state       | meaning
  // ST_WAIT     | resynchronising, waiting for an all-spacer word
  // ST_EVAL     | ack low, waiting for a complete codeword
  // ST_HOLD     | word offered downstream, ack high
  // ST_RTZ      | word consumed, ack high until spacer returns
  // ST_ERR      | fault latched until err_clr
  localparam logic [2:0] ST_WAIT = 3'd0;
  localparam logic [2:0] ST_EVAL = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_RTZ  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic [N-1:0] s_t_q, s_f_q;
  logic [N-1:0] data_q, data_d;
  logic [2:0]   state_q, state_d;
  logic [1:0]   code_q, code_d;
  logic         seen_q, seen_d;
  logic         cls_spacer, cls_complete, cls_illegal, mono_viol, timeout_hit;

  // Input stage has no reset so a codeword held across reset is not seen as a spacer.
  always_ff @(posedge clk_i) begin
    s_t_q <= dr_if.in_t;
    s_f_q <= dr_if.in_f;
  end

  assign cls_spacer   = ~|(s_t_q | s_f_q);
  assign cls_illegal  = |(s_t_q & s_f_q);
  assign cls_complete = &(s_t_q ^ s_f_q);
  // data_q holds the captured true rails; its complement is the captured false rails.
  assign mono_viol    = |((s_t_q & ~data_q) | (s_f_q & data_q));

`ifdef DUAL_RAIL_DEC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cls_partial;

  assign cls_partial = ~cls_spacer & ~cls_complete & ~cls_illegal;
  assign timeout_hit = cls_partial && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_EVAL && cls_partial) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  // Without the counter TIMEOUT has no effect.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    code_d  = code_q;
    seen_d  = seen_q;
    case (state_q)
      ST_WAIT: if (cls_spacer) state_d = ST_EVAL;
      ST_EVAL: begin
        if (cls_complete) begin
          data_d  = s_t_q;
          seen_d  = 1'b0;
          state_d = ST_HOLD;
        end else if (cls_illegal) begin
          code_d  = 2'b01;
          state_d = ST_ERR;
        end else if (timeout_hit) begin
          code_d  = 2'b10;
          state_d = ST_ERR;
        end
      end
      ST_HOLD, ST_RTZ: begin
        if (cls_illegal) begin
          code_d  = 2'b01;
          state_d = ST_ERR;
        end else if (mono_viol) begin
          code_d  = 2'b11;
          state_d = ST_ERR;
        end else if (state_q == ST_HOLD) begin
          if (cls_spacer) seen_d = 1'b1;
          if (dr_if.out_ready) state_d = (seen_q || cls_spacer) ? ST_EVAL : ST_RTZ;
        end else if (cls_spacer) begin
          state_d = ST_EVAL;
        end
      end
      ST_ERR: begin
        if (dr_if.err_clr) begin
          code_d  = 2'b00;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_WAIT;
      data_q  <= '0;
      code_q  <= 2'b00;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      code_q  <= code_d;
      seen_q  <= seen_d;
    end
  end

  assign dr_if.ack       = (state_q == ST_HOLD) || (state_q == ST_RTZ);
  assign dr_if.out_valid = (state_q == ST_HOLD);
  assign dr_if.err       = (state_q == ST_ERR);
  assign dr_if.err_code  = code_q;
  assign dr_if.out_data  = data_q;
endmodule

// File: doc/dual_rail_decoder.md
# dual_rail_decoder

Receive-side terminus of the dual-rail (true/false rail) datapath that protects the AES-256 core against side-channel leakage. Accepts an N-bit dual-rail word under the return-to-spacer protocol and registers it. Performs completion and codeword-legality detection, converts to single-rail and hands the result downstream over a valid/ready handshake. Returns a 4-phase acknowledge upstream and flags any protocol or encoding violation as a fault.

## Interface
- N, 128: datapath width in bits.
- TIMEOUT, 16: maximum consecutive partial-codeword cycles in EVAL before a fault; ≥2.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_t  in  N  true rails from the dual-rail core.
- in_f  in  N  false rails from the dual-rail core.
- ack  out  1  4-phase acknowledge to the upstream sender.
- out_data  out  N  single-rail decoded word.
- out_valid  out  1  out_data holds a new word.
- out_ready  in  1  downstream accepts out_data.
- err  out  1  sticky fault flag.
- err_code  out  2  01 = illegal 11 rail pair, 10 = completion timeout, 11 = monotonicity violation, 00 = none.
- err_clr  in  1  clears a fault; single-cycle pulse.

## Operation
- Stage 1: in_t/in_f are registered unconditionally every cycle into s_t/s_f. All classification uses s_t/s_f only.
- Classification per cycle:
  - SPACER: all bits 00.
  - COMPLETE: every bit exactly one rail high.
  - ILLEGAL: any bit 11.
  - PARTIAL: otherwise.
- FSM states and transitions:
  - WAIT_SPACER (reset state, ack=0). SPACER moves to EVAL; all other classes are ignored.
  - EVAL (ack=0). COMPLETE captures out_data<=s_t, sets out_valid=1 and ack=1, and moves to HOLD. ILLEGAL moves to ERR. SPACER clears the timeout counter. PARTIAL increments it.
  - HOLD (ack=1, out_valid=1). Latches spacer_seen on SPACER. On out_ready, out_valid clears. The next state is then EVAL (ack=0) if spacer_seen or the current class is SPACER; otherwise it is RTZ.
  - RTZ (ack=1, out_valid=0). SPACER moves to EVAL with ack=0.
  - ERR (ack=0, out_valid=0, err=1). Holds until err_clr, then moves to WAIT_SPACER with err=0 and err_code=00.
- Monotonicity rule in HOLD/RTZ:
  - A rail that is 0 in the captured codeword (s_t or s_f) must not rise.
  - A violation moves to ERR with code 11.
  - Rails only fall during return-to-spacer.
- Fault priority when several occur in one cycle: ILLEGAL (01) > monotonicity (11) > timeout (10). err_code is written once on ERR entry and is never overwritten while in ERR.
- ILLEGAL in HOLD/RTZ also moves to ERR. In WAIT_SPACER it is ignored, because that state covers resynchronisation.
- out_data is stable whenever out_valid=1, and keeps its last value otherwise.
- Reset mid-operation: state, counter, spacer_seen and all outputs return to reset values on the next edge.

## Timing
- Reset values:
  - ack=0, out_valid=0, out_data=0, err=0, err_code=00.
  - State WAIT_SPACER, counter=0, spacer_seen=0.
- Latency: a COMPLETE word present at in_t/in_f before edge k raises out_valid and ack after edge k+1, a 2-cycle latency.
- Handshake: the transfer occurs on the edge where out_valid=1 and out_ready=1. out_ready=1 during any cycle with out_valid=0 has no effect.
- The spacer-to-ack-low delay is also 2 edges.
- Throughput is at most one word per 4 cycles (codeword, spacer, ack-low, next codeword) with out_ready held at 1.
- Timeout: the fault is entered on the edge where the counter reaches TIMEOUT, i.e. after TIMEOUT consecutive PARTIAL cycles. A COMPLETE word on that same cycle wins and no fault is raised.
- err_clr while not in ERR is ignored. err_clr coincident with a new fault is also ignored, and the fault is taken.

## Configuration
- DUAL_RAIL_DEC_TIMEOUT_EN:
  - Defined: the completion-timeout counter and code 10 are compiled in, as described above.
  - Undefined: no counter exists; PARTIAL waits indefinitely in EVAL and err_code 10 is never produced. The TIMEOUT parameter is accepted but unused.

## Test plan
- Reset, then spacer, then in_t=0x0123…EF / in_f=~in_t -> out_valid and ack high 2 edges after the codeword, out_data=0x0123…EF. Then spacer with out_ready=1 -> ack low 2 edges after the spacer, and out_valid low after the handshake.
- out_ready held 0 for 10 cycles with spacer returned meanwhile -> out_data and out_valid stable. On out_ready=1, the FSM goes directly to EVAL with ack=0.
- Bit 5 driven 11 in EVAL -> err=1, err_code=01, ack=0. Then err_clr pulse, spacer, codeword -> normal decode resumes.
- Macro defined, TIMEOUT=16, half the bits valid and the rest 00 for 16 cycles -> err_code=10. Same stimulus with the macro undefined -> no fault, and completing the word then decodes normally.
- In HOLD, the captured-0 false rail of bit 0 rises -> err_code=11. A simultaneous 11 on bit 3 -> err_code=01.
- rst_n=0 for one cycle while in HOLD -> all outputs 0 on the next edge. A codeword without a preceding spacer is then ignored.
